// File: rtl/text_pkg.sv
// text_pkg: shared types and constants for the character text buffer.
// Used by the write-side cursor controller and the VGA read side.
package text_pkg;

    // Controller states
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Character codes
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    // Screen geometry defaults
    localparam int DEF_COL_W = 5;
    localparam int DEF_ROW_W = 2;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_cursor_ctrl_hold.sv
// byte_hold_reg: one-entry byte buffer that parks a byte
// while the controller is busy clearing the screen.
module byte_hold_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       drain_i,
    input  logic [7:0] data_i,
    output logic       full_o,
    output logic [7:0] data_o,
    output logic       drop_o
);

    logic       full_q, full_d;
    logic [7:0] data_q, data_d;

    // A load is accepted when empty or when the entry drains this cycle
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (drain_i) begin
            full_d = 1'b0;
        end
        if (load_i && (!full_q || drain_i)) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= 8'h00;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign drop_o = load_i && full_q && !drain_i;

endmodule

// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: turns received UART bytes into text RAM writes
// with cursor placement, wrap, CR, BS and form-feed clear-screen.
module text_cursor_ctrl
    import text_pkg::*;
#(
    parameter int         COL_W     = DEF_COL_W,
    parameter int         ROW_W     = DEF_ROW_W,
    parameter logic [7:0] FILL_CHAR = CH_SPACE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             ram_we,
    output logic [ROW_W-1:0] ram_row,
    output logic [COL_W-1:0] ram_col,
    output logic [7:0]       ram_wdata,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic             busy,
    output logic             overflow
);

    localparam int N = ROW_W + COL_W;
    localparam logic [N-1:0] CELL_LAST = '1;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [N-1:0]     cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [ROW_W-1:0] wrow_q, wrow_d;
    logic [COL_W-1:0] wcol_q, wcol_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             ovf_q;

    logic       hold_full, hold_drop, hold_load, hold_drain;
    logic [7:0] hold_data;
    logic       pb_valid;
    logic [7:0] pb_data;

    // Held byte has priority; a new byte refills the hold slot behind it
    assign hold_drain = (state_q == IDLE) && hold_full;
    assign hold_load  = rx_valid && ((state_q == CLEAR) || hold_full);
    assign pb_valid   = (state_q == IDLE) && (hold_full || rx_valid);
    assign pb_data    = hold_full ? hold_data : rx_data;

    byte_hold_reg u_hold (
        .clk     (clk),
        .reset   (reset),
        .load_i  (hold_load),
        .drain_i (hold_drain),
        .data_i  (rx_data),
        .full_o  (hold_full),
        .data_o  (hold_data),
        .drop_o  (hold_drop)
    );

    // Byte decode, cursor movement and clear-sequence stepping
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (pb_valid) begin
                    unique case (1'b1)
                        is_print(pb_data): begin
                            we_d    = 1'b1;
                            wrow_d  = row_q;
                            wcol_d  = col_q;
                            wdata_d = pb_data;
                            col_d   = col_q + 1'b1;
                            if (col_q == '1) begin
                                row_d = row_q + 1'b1;
                            end
                        end
                        (pb_data == CH_CR): begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end
                        (pb_data == CH_BS): begin
                            if ((row_q != '0) || (col_q != '0)) begin
                                col_d = col_q - 1'b1;
                                if (col_q == '0) begin
                                    row_d = row_q - 1'b1;
                                end
                                we_d    = 1'b1;
                                wrow_d  = row_d;
                                wcol_d  = col_d;
                                wdata_d = FILL_CHAR;
                            end
                        end
                        (pb_data == CH_FF): begin
                            state_d = CLEAR;
                            cnt_d   = '0;
                            row_d   = '0;
                            col_d   = '0;
                            we_d    = 1'b1;
                            wrow_d  = '0;
                            wcol_d  = '0;
                            wdata_d = FILL_CHAR;
                        end
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                if (cnt_q == CELL_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d            = cnt_q + 1'b1;
                    we_d             = 1'b1;
                    {wrow_d, wcol_d} = cnt_q + 1'b1;
                    wdata_d          = FILL_CHAR;
                end
            end
            default: ;
        endcase
    end

    // State, cursor and registered RAM write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            wdata_q <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            wdata_q <= wdata_d;
            ovf_q   <= hold_drop;
        end
    end

    assign ram_we     = we_q;
    assign ram_row    = wrow_q;
    assign ram_col    = wcol_q;
    assign ram_wdata  = wdata_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign busy       = (state_q == CLEAR);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// tb_text_cursor_ctrl: table-driven and sequence checks of the
// text cursor controller with a write-port scoreboard.
module tb_text_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ram_we;
    logic [1:0] ram_row;
    logic [4:0] ram_col;
    logic [7:0] ram_wdata;
    logic [1:0] cursor_row;
    logic [4:0] cursor_col;
    logic       busy;
    logic       overflow;

    text_cursor_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .ram_we     (ram_we),
        .ram_row    (ram_row),
        .ram_col    (ram_col),
        .ram_wdata  (ram_wdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] r;
        logic [4:0] c;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] d;
        logic       we;
        int         wr;
        int         wc;
        logic [7:0] wd;
        int         cr;
        int         cc;
    } vec_t;

    wr_t  wq[$];
    wr_t  mon_e;
    vec_t vt[12];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int r, input int c, input logic [7:0] d);
        wr_t e;
        e.r = 2'(r);
        e.c = 5'(c);
        e.d = d;
        wq.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_cur(input string nm, input int r, input int c);
        chk(nm, 32'({cursor_row, cursor_col}), 32'({2'(r), 5'(c)}));
    endtask

    // Scoreboard: every observed write must match the oldest expectation
    always @(negedge clk) begin
        if (mon_en && !reset && ram_we) begin
            if (wq.size() == 0) begin
                chk("spurious_we", 32'(ram_we), 32'd0);
            end else begin
                mon_e = wq.pop_front();
                chk("wr_addr", 32'({ram_row, ram_col}),
                    32'({mon_e.r, mon_e.c}));
                chk("wr_data", 32'(ram_wdata), 32'(mon_e.d));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nfill, nbusy, novf, tovf, tfall, tb_w;

        vt[0]  = '{8'h0D, 1'b0, 0, 0,  8'h00, 3, 0};
        vt[1]  = '{8'h08, 1'b1, 2, 31, 8'h20, 2, 31};
        vt[2]  = '{8'h07, 1'b0, 0, 0,  8'h00, 2, 31};
        vt[3]  = '{8'h7F, 1'b0, 0, 0,  8'h00, 2, 31};
        vt[4]  = '{8'h9A, 1'b0, 0, 0,  8'h00, 2, 31};
        vt[5]  = '{8'h7E, 1'b1, 2, 31, 8'h7E, 3, 0};
        vt[6]  = '{8'h20, 1'b1, 3, 0,  8'h20, 3, 1};
        vt[7]  = '{8'h08, 1'b1, 3, 0,  8'h20, 3, 0};
        vt[8]  = '{8'h0D, 1'b0, 0, 0,  8'h00, 0, 0};
        vt[9]  = '{8'h08, 1'b0, 0, 0,  8'h00, 0, 0};
        vt[10] = '{8'h1F, 1'b0, 0, 0,  8'h00, 0, 0};
        vt[11] = '{8'h80, 1'b0, 0, 0,  8'h00, 0, 0};

        @(negedge clk);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'({ram_row, ram_col}), 32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        chk_cur("rst_cursor", 0, 0);
        chk("rst_busy", 32'({busy, overflow}), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // 'A' then 127 'x': write position walks row-major and wraps
        for (int i = 0; i < 128; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'h41 : 8'h78;
            push(i / 32, i % 32, b);
            send(b);
            if (i == 0) begin
                chk("A_we", 32'(ram_we), 32'd1);
                chk_cur("A_cursor", 0, 1);
            end
            if (i == 31) chk_cur("wrap_row", 1, 0);
            if (i == 127) chk_cur("wrap_screen", 0, 0);
        end

        // Walk the cursor to (2,5)
        for (int i = 0; i < 69; i++) begin
            push(i / 32, i % 32, 8'h79);
            send(8'h79);
        end
        chk_cur("at_2_5", 2, 5);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].we) push(vt[i].wr, vt[i].wc, vt[i].wd);
            send(vt[i].d);
            chk($sformatf("vec%0d_we", i), 32'(ram_we), 32'(vt[i].we));
            chk_cur($sformatf("vec%0d_cursor", i), vt[i].cr, vt[i].cc);
        end

        // Back-to-back bytes every cycle
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            push(0, i, 8'h61 + 8'(i));
            rx_valid = 1'b1;
            rx_data  = 8'h61 + 8'(i);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        @(negedge clk);
        chk_cur("b2b_cursor", 0, 4);

        // Form feed with one held byte and one dropped byte
        for (int i = 0; i < 128; i++) push(i / 32, i % 32, 8'h20);
        push(0, 0, 8'h42);
        nfill = 0;
        nbusy = 0;
        novf  = 0;
        tovf  = -1;
        tfall = -1;
        tb_w  = -1;
        for (int t = 0; t < 136; t++) begin
            @(posedge clk);
            #1;
            rx_valid = (t == 0) || (t == 3) || (t == 4);
            rx_data  = (t == 0) ? 8'h0C : (t == 3) ? 8'h42 : 8'h43;
            @(negedge clk);
            if (busy) nbusy++;
            if (busy && ram_we) nfill++;
            if (overflow) begin
                novf++;
                tovf = t;
            end
            if (ram_we && ram_wdata == 8'h42) tb_w = t;
            if (!busy && t > 0 && tfall < 0) tfall = t;
        end
        chk("clr_fills", 32'(nfill), 32'd128);
        chk("clr_busy_cycles", 32'(nbusy), 32'd128);
        chk("clr_ovf_count", 32'(novf), 32'd1);
        chk("clr_ovf_cycle", 32'(tovf), 32'd5);
        chk("clr_busy_fall", 32'(tfall), 32'd129);
        chk("clr_held_write", 32'(tb_w), 32'd130);
        chk_cur("clr_cursor", 0, 1);

        // Reset 40 cycles into a clear
        for (int i = 0; i < 128; i++) push(i / 32, i % 32, 8'h20);
        send(8'h0C);
        repeat (39) @(negedge clk);
        chk("midclr_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_we", 32'(ram_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk_cur("midrst_cursor", 0, 0);
        wq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(0, 0, 8'h5A);
        send(8'h5A);
        chk_cur("post_rst_cursor", 0, 1);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(wq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
